// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared constants for the sequential divider
package div_seq_pkg;

  // Operand/result width; the datapath is built and tested for 32 bits.
  localparam int DIV_WIDTH = 32;

  // FSM encoding (2-bit, kept as plain constants for legacy tools).
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  // Quotient reported when the divisor is zero.
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = '1;

  // Width of the iteration counter (must hold DIV_WIDTH-1).
  localparam int CNT_W = 6;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract iteration
module div_step
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_fits;

  // Shift the next dividend bit into the partial remainder, trial-subtract,
  // and keep the difference only when it did not borrow.
  always_comb begin
    w_shift = {i_rem, i_quo[WIDTH-1]};
    w_diff  = w_shift - {2'b00, i_dvs};
    w_fits  = ~w_diff[WIDTH+1];
    o_rem   = w_fits ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
    o_quo   = {i_quo[WIDTH-2:0], w_fits};
  end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle signed/unsigned restoring divider
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] QUOT,
  output logic [WIDTH-1:0] REM,
  output logic             DIV_BY_ZERO
);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_signed;
  logic             r_dvd_neg;
  logic             r_dvs_neg;
  logic [WIDTH:0]   r_prem;
  logic [WIDTH-1:0] r_pquo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_prem_next;
  logic [WIDTH-1:0] w_pquo_next;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic             w_last_step;

  // The quotient register starts as the dividend magnitude and fills with
  // quotient bits from the right as the dividend bits shift out the top.
  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem (r_prem),
    .i_quo (r_pquo),
    .i_dvs (r_dvs),
    .o_rem (w_prem_next),
    .o_quo (w_pquo_next)
  );

  // Operand magnitudes at accept time and sign correction of the result;
  // negating 0x80000000 wraps back to itself, which is the wanted magnitude.
  always_comb begin
    w_dvd_mag   = (SIGNED && DIVIDEND[WIDTH-1]) ? (~DIVIDEND + WIDTH'(1)) : DIVIDEND;
    w_dvs_mag   = (SIGNED && DIVISOR[WIDTH-1])  ? (~DIVISOR + WIDTH'(1))  : DIVISOR;
    w_quo_fix   = (r_signed && (r_dvd_neg ^ r_dvs_neg)) ? (~r_pquo + WIDTH'(1)) : r_pquo;
    w_rem_fix   = (r_signed && r_dvd_neg) ? (~r_prem[WIDTH-1:0] + WIDTH'(1))
                                          : r_prem[WIDTH-1:0];
    w_last_step = (r_count == CNT_W'(WIDTH - 1));
  end

  // Control FSM and datapath registers; results are only written on accept
  // (zero divisor) or in FIX, so they hold steady between operations.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_signed  <= 1'b0;
      r_dvd_neg <= 1'b0;
      r_dvs_neg <= 1'b0;
      r_prem    <= '0;
      r_pquo    <= '0;
      r_dvs     <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_signed  <= SIGNED;
            r_dvd_neg <= DIVIDEND[WIDTH-1];
            r_dvs_neg <= DIVISOR[WIDTH-1];
            r_count   <= '0;
            r_prem    <= '0;
            if (DIVISOR == '0) begin
              r_quot  <= DIV0_QUOT;
              r_rem   <= DIVIDEND;
              r_dbz   <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_pquo  <= w_dvd_mag;
              r_dvs   <= w_dvs_mag;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_prem  <= w_prem_next;
          r_pquo  <= w_pquo_next;
          r_count <= r_count + CNT_W'(1);
          if (w_last_step) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_quot  <= w_quo_fix;
          r_rem   <= w_rem_fix;
          r_dbz   <= 1'b0;
          r_state <= S_FIN;
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Status and results are decoded from registered state only.
  always_comb begin
    BUSY        = (r_state == S_CALC) || (r_state == S_FIX);
    DONE        = (r_state == S_FIN);
    QUOT        = r_quot;
    REM         = r_rem;
    DIV_BY_ZERO = r_dbz;
  end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - randomized self-checking bench for div_seq
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        dbz;

  int n_checks;
  int n_pass;

  div_seq #(.WIDTH(32)) dut (
    .CLK         (clk),
    .RST         (rst),
    .START       (start),
    .SIGNED      (sgn),
    .DIVIDEND    (dividend),
    .DIVISOR     (divisor),
    .BUSY        (busy),
    .DONE        (done),
    .QUOT        (quot),
    .REM         (rem),
    .DIV_BY_ZERO (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Golden model: plain 64-bit integer arithmetic, C-style truncation.
  task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      z  = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endtask

  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    sgn = s; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sgn = 1'($urandom); dividend = $urandom; divisor = $urandom;
  endtask

  // Samples on falling edges; lat counts edges from accept to DONE sample.
  // poke > 0 pulses START (other operands) at that cycle; poke < 0 pulses
  // START in the DONE cycle itself.
  task automatic wait_done(input int poke, output logic [31:0] q, output logic [31:0] r,
                           output logic z, output int lat, output int busy_cnt);
    bit seen;
    seen = 0; lat = 0; busy_cnt = 0; q = '0; r = '0; z = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (poke > 0 && lat == poke) begin
        start = 1'b1; sgn = 1'b0; dividend = 32'd777; divisor = 32'd5;
      end else if (poke > 0 && lat == poke + 1) begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1; q = quot; r = rem; z = dbz;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    if (poke < 0) begin
      start = 1'b1; sgn = 1'b0; dividend = 32'd40; divisor = 32'd4;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic run_case(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat);
    logic [31:0] q, r, eq, er;
    logic z, ez;
    int lat, bc;
    ref_div(s, a, b, eq, er, ez);
    start_op(s, a, b);
    wait_done(0, q, r, z, lat, bc);
    check({tag, "_quot"}, 64'(q), 64'(eq));
    check({tag, "_rem"}, 64'(r), 64'(er));
    check({tag, "_dbz"}, 64'(z), 64'(ez));
    if (exp_lat > 0) check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    logic [31:0] q, r, eq, er, a, b;
    logic z, ez, s;
    int lat, bc, n_done;

    n_checks = 0; n_pass = 0;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_quot", 64'(quot), 64'd0);
    check("rst_rem", 64'(rem), 64'd0);
    check("rst_dbz", 64'(dbz), 64'd0);
    rst = 1'b0;

    // 100 / 7 unsigned with latency and busy window
    start_op(1'b0, 32'd100, 32'd7);
    wait_done(0, q, r, z, lat, bc);
    check("u100_7_quot", 64'(q), 64'd14);
    check("u100_7_rem", 64'(r), 64'd2);
    check("u100_7_dbz", 64'(z), 64'd0);
    check("u100_7_lat", 64'(lat), 64'd34);
    check("u100_7_busy", 64'(bc), 64'd33);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    repeat (4) @(negedge clk);
    check("hold_quot", 64'(quot), 64'd14);
    check("hold_rem", 64'(rem), 64'd2);

    run_case("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34);
    check("s_m7_2_abs_q", 64'(quot), 64'hFFFF_FFFD);
    run_case("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 34);
    check("u_m7_2_abs_q", 64'(quot), 64'h7FFF_FFFC);
    run_case("div0", 1'b1, 32'h1234_5678, 32'd0, 1);
    check("div0_abs_q", 64'(quot), 64'hFFFF_FFFF);
    check("div0_hold_dbz", 64'(dbz), 64'd1);
    run_case("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34);
    check("s_min_m1_abs_q", 64'(quot), 64'h8000_0000);
    run_case("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 34);
    run_case("u_div0", 1'b0, 32'd5, 32'd0, 1);

    // START mid-CALC must be ignored
    start_op(1'b0, 32'd1000, 32'd10);
    wait_done(5, q, r, z, lat, bc);
    check("midstart_quot", 64'(q), 64'd100);
    check("midstart_rem", 64'(r), 64'd0);
    check("midstart_lat", 64'(lat), 64'd34);

    // START in the DONE cycle must be ignored
    start_op(1'b0, 32'd81, 32'd9);
    wait_done(-1, q, r, z, lat, bc);
    check("donestart_quot", 64'(q), 64'd9);
    check("donestart_busy", 64'(busy), 64'd0);
    check("donestart_done", 64'(done), 64'd0);
    @(negedge clk);
    check("donestart_idle", 64'(busy), 64'd0);

    // Reset at CALC cycle 10, START held together with reset
    start_op(1'b0, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    rst = 1'b1; start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_quot", 64'(quot), 64'd0);
    check("abort_rem", 64'(rem), 64'd0);
    check("abort_dbz", 64'(dbz), 64'd0);
    rst = 1'b0; start = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("abort_quiet", 64'(n_done), 64'd0);
    run_case("after_rst_9_3", 1'b0, 32'd9, 32'd3, 34);

    // Random sweep
    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        3: begin b = $urandom; a = 32'h8000_0000; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      ref_div(s, a, b, eq, er, ez);
      start_op(s, a, b);
      wait_done(0, q, r, z, lat, bc);
      check("rnd_quot", 64'(q), 64'(eq));
      check("rnd_rem", 64'(r), 64'(er));
      check("rnd_dbz", 64'(z), 64'(ez));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
